// File: rtl/lcd_i2c_stream.sv
// rtl/lcd_i2c_stream.sv - HD44780 byte to PCF8574 I2C backpack writer (4-bit mode, open-drain).
module lcd_i2c_stream #(
  parameter int         CLK_HZ    = 50000000,
  parameter int         I2C_HZ    = 100000,
  parameter logic [6:0] DEV_ADDR  = 7'h27,
  parameter bit         BACKLIGHT = 1'b1,
  parameter int         LONG_WAIT = 80000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       busy,
  output logic       ack_err,
  inout  wire        scl,
  inout  wire        sda
);

  localparam int DIV = CLK_HZ / (4 * I2C_HZ);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HW  = $clog2(LONG_WAIT + 1);

  typedef enum logic [2:0] {IDLE, START, BYTE, ACK, STOP, HOLD} state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [1:0]    q;
  logic [2:0]    bit_idx;
  logic [2:0]    byte_idx;
  logic          rs_q;
  logic [7:0]    data_q;
  logic          nack_q;
  logic [HW-1:0] hold_cnt;

  logic       tick;
  logic       slot_end;
  logic       long_cmd;
  logic [3:0] nib;
  logic [7:0] cur_byte;
  logic       scl_lo;
  logic       sda_lo;

  assign tick     = (div_cnt == DW'(DIV - 1));
  assign slot_end = tick && (q == 2'd3);
  assign long_cmd = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);
  assign in_ready = (state == IDLE);
  assign busy     = !in_ready;

  // Byte 0 is the address; bytes 1..4 strobe EN high then low for each nibble.
  assign nib      = (byte_idx < 3'd3) ? data_q[7:4] : data_q[3:0];
  assign cur_byte = (byte_idx == 3'd0) ? {DEV_ADDR, 1'b0}
                                       : {nib, 1'(BACKLIGHT), byte_idx[0], 1'b0, rs_q};

  always_comb begin
    scl_lo = 1'b0;
    sda_lo = 1'b0;
    case (state)
      START: begin
        scl_lo = (q == 2'd3);
        sda_lo = q[1];
      end
      BYTE: begin
        scl_lo = (q == 2'd0) || (q == 2'd3);
        sda_lo = !cur_byte[bit_idx];
      end
      ACK: begin
        scl_lo = (q == 2'd0) || (q == 2'd3);
      end
      STOP: begin
        scl_lo = (q == 2'd0);
        sda_lo = !q[1];
      end
      default: ;
    endcase
  end

  assign scl = scl_lo ? 1'b0 : 1'bz;
  assign sda = sda_lo ? 1'b0 : 1'bz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      q        <= 2'd0;
      bit_idx  <= 3'd7;
      byte_idx <= 3'd0;
      rs_q     <= 1'b0;
      data_q   <= 8'h00;
      nack_q   <= 1'b0;
      hold_cnt <= '0;
      ack_err  <= 1'b0;
    end else begin
      if (state == IDLE) begin
        div_cnt <= '0;
        q       <= 2'd0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + DW'(1);
        if (tick) q <= q + 2'd1;
      end

      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= START;
            rs_q     <= in_rs;
            data_q   <= in_data;
            ack_err  <= 1'b0;
            bit_idx  <= 3'd7;
            byte_idx <= 3'd0;
          end
        end
        START: if (slot_end) state <= BYTE;
        BYTE: begin
          if (slot_end) begin
            if (bit_idx == 3'd0) state <= ACK;
            else bit_idx <= bit_idx - 3'd1;
          end
        end
        ACK: begin
          if (tick && q == 2'd1) nack_q <= sda;
          if (slot_end) begin
            if (nack_q) begin
              ack_err <= 1'b1;
              state   <= STOP;
            end else if (byte_idx == 3'd4) begin
              state <= STOP;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              bit_idx  <= 3'd7;
              state    <= BYTE;
            end
          end
        end
        STOP: begin
          if (slot_end) begin
            // A NACKed clear/home never reached the LCD, so no hold-off is needed.
            if (long_cmd && !ack_err) begin
              state    <= HOLD;
              hold_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        HOLD: begin
          hold_cnt <= hold_cnt + HW'(1);
          if (hold_cnt == HW'(LONG_WAIT - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_i2c_stream.sv
// tb/tb_lcd_i2c_stream.sv - directed vector bench for lcd_i2c_stream with an I2C slave model.
module tb_lcd_i2c_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_rs;
  logic [7:0] in_data;
  logic       in_ready;
  logic       busy;
  logic       ack_err;
  wire        scl;
  wire        sda;

  logic        slave_sda_lo = 1'b0;
  logic [7:0]  rx_q[$];
  int          nack_idx = -1;
  int          bit_cnt = 0;
  logic [7:0]  shreg = 8'h00;
  int          stop_cnt = 0;
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;

  int n_chk = 0;
  int n_fail = 0;

  pullup (scl);
  pullup (sda);
  assign sda = slave_sda_lo ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  lcd_i2c_stream #(
    .CLK_HZ(1600000), .I2C_HZ(100000), .DEV_ADDR(7'h27), .BACKLIGHT(1'b1), .LONG_WAIT(100)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_rs(in_rs), .in_data(in_data),
    .in_ready(in_ready), .busy(busy), .ack_err(ack_err), .scl(scl), .sda(sda)
  );

  // Bus monitor and slave: decodes START/STOP/bytes, ACKs every byte except nack_idx.
  always @(negedge clk) begin
    if (scl && prev_scl && prev_sda && !sda) begin
      bit_cnt = 0;
    end else if (scl && prev_scl && !prev_sda && sda) begin
      stop_cnt = stop_cnt + 1;
    end else if (scl && !prev_scl) begin
      if (bit_cnt < 8) begin
        shreg   = {shreg[6:0], sda};
        bit_cnt = bit_cnt + 1;
        if (bit_cnt == 8) rx_q.push_back(shreg);
      end else begin
        bit_cnt = 0;
      end
    end else if (!scl && prev_scl) begin
      slave_sda_lo = (bit_cnt == 8) && ((int'(rx_q.size()) - 1) != nack_idx);
    end
    prev_scl = scl;
    prev_sda = sda;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_req(input logic rs, input logic [7:0] d, input int nidx,
                         output int cycles, output logic err_at_accept);
    @(negedge clk);
    rx_q.delete();
    stop_cnt = 0;
    nack_idx = nidx;
    in_rs    = rs;
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid      = 1'b0;
    err_at_accept = ack_err;
    cycles        = 0;
    while (!in_ready && cycles < 5000) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic chk_bytes(input string nm, input int n, input logic [39:0] exp);
    logic [39:0] e;
    e = exp;
    chk({nm, " count"}, 64'(rx_q.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (i < rx_q.size()) chk($sformatf("%s byte%0d", nm, i), 64'(rx_q[i]), 64'(e[39-8*i -: 8]));
    end
  endtask

  typedef struct {
    logic        rs;
    logic [7:0]  d;
    int          nidx;
    int          nbytes;
    logic [39:0] bytes;
    int          cycles;
    logic        err;
  } vec_t;

  initial begin
    vec_t vecs[9];
    int   cyc;
    logic e0;

    vecs[0] = '{1'b1, 8'h50, -1, 5, 40'h4E5D590D09, 752, 1'b0};
    vecs[1] = '{1'b0, 8'h01, -1, 5, 40'h4E0C081C18, 852, 1'b0};
    vecs[2] = '{1'b1, 8'h50,  0, 1, 40'h4E00000000, 176, 1'b1};
    vecs[3] = '{1'b1, 8'h50,  3, 4, 40'h4E5D590D00, 608, 1'b1};
    vecs[4] = '{1'b0, 8'h02, -1, 5, 40'h4E0C082C28, 852, 1'b0};
    vecs[5] = '{1'b0, 8'h01,  0, 1, 40'h4E00000000, 176, 1'b1};
    vecs[6] = '{1'b0, 8'h04, -1, 5, 40'h4E0C084C48, 752, 1'b0};
    vecs[7] = '{1'b1, 8'h03, -1, 5, 40'h4E0D093D39, 752, 1'b0};
    vecs[8] = '{1'b0, 8'h03, -1, 5, 40'h4E0C083C38, 852, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_rs = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 64'(in_ready), 64'(1));
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset ack_err", 64'(ack_err), 64'(0));
    chk("reset scl", 64'(scl), 64'(1));
    chk("reset sda", 64'(sda), 64'(1));
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 9; v++) begin
      run_req(vecs[v].rs, vecs[v].d, vecs[v].nidx, cyc, e0);
      chk($sformatf("v%0d err cleared on accept", v), 64'(e0), 64'(0));
      chk($sformatf("v%0d ready latency", v), 64'(cyc), 64'(vecs[v].cycles));
      chk($sformatf("v%0d ack_err", v), 64'(ack_err), 64'(vecs[v].err));
      chk($sformatf("v%0d busy", v), 64'(busy), 64'(0));
      chk($sformatf("v%0d stops", v), 64'(stop_cnt), 64'(1));
      chk_bytes($sformatf("v%0d", v), vecs[v].nbytes, vecs[v].bytes);
    end

    // Reset while the first address bit is on the bus.
    @(negedge clk);
    rx_q.delete(); nack_idx = -1;
    in_rs = 1'b1; in_data = 8'h50; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    chk("pre-reset scl low", 64'(scl), 64'(0));
    chk("pre-reset sda low", 64'(sda), 64'(0));
    #2 rst = 1'b1;
    #1;
    chk("async reset scl", 64'(scl), 64'(1));
    chk("async reset sda", 64'(sda), 64'(1));
    chk("async reset in_ready", 64'(in_ready), 64'(1));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_req(1'b1, 8'h50, -1, cyc, e0);
    chk("post-reset latency", 64'(cyc), 64'(752));
    chk("post-reset ack_err", 64'(ack_err), 64'(0));
    chk("post-reset stops", 64'(stop_cnt), 64'(1));
    chk_bytes("post-reset", 5, 40'h4E5D590D09);

    // in_valid held throughout: data changes while busy are ignored, then back-to-back.
    @(negedge clk);
    rx_q.delete(); stop_cnt = 0; nack_idx = -1;
    in_rs = 1'b1; in_data = 8'h50; in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("b2b first accept", 64'(in_ready), 64'(0));
    cyc = 0;
    while (!in_ready && cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 10) begin
        in_rs   = 1'b0;
        in_data = 8'h3C;
      end
    end
    chk("b2b first latency", 64'(cyc), 64'(752));
    chk("b2b first stops", 64'(stop_cnt), 64'(1));
    chk_bytes("b2b first", 5, 40'h4E5D590D09);
    rx_q.delete(); stop_cnt = 0;
    @(posedge clk);
    #1;
    chk("b2b second accept", 64'(in_ready), 64'(0));
    in_valid = 1'b0;
    cyc = 0;
    while (!in_ready && cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("b2b second latency", 64'(cyc), 64'(752));
    chk("b2b second stops", 64'(stop_cnt), 64'(1));
    chk_bytes("b2b second", 5, 40'h4E3C38CCC8);
    repeat (20) @(posedge clk);
    #1;
    chk("b2b no third", 64'(in_ready), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_i2c_stream.md
LCD_I2C_STREAM -- requirements
Module: lcd_i2c_stream

Interface
REQ-001 Parameter CLK_HZ, 50000000, system clock frequency in Hz.
REQ-002 Parameter I2C_HZ, 100000, SCL frequency in Hz; DIV = CLK_HZ/(4*I2C_HZ) SHALL be >= 2.
REQ-003 Parameter DEV_ADDR, 7'h27, 7-bit I2C address of the PCF8574 LCD backpack.
REQ-004 Parameter BACKLIGHT, 1, value driven on expander bit P3.
REQ-005 Parameter LONG_WAIT, 80000, clock cycles to hold off after a clear or home command.
REQ-006 clk  input  1  system clock; one clock domain.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 in_valid  input  1  request carries an LCD byte.
REQ-009 in_rs  input  1  HD44780 RS: 0 = command, 1 = data.
REQ-010 in_data  input  8  HD44780 byte.
REQ-011 in_ready  output  1  block can accept a request.
REQ-012 busy  output  1  transaction or hold-off in progress.
REQ-013 ack_err  output  1  sticky NACK flag for the last transaction.
REQ-014 scl  inout  1  open-drain; drives 0 or Z only.
REQ-015 sda  inout  1  open-drain; drives 0 or Z only; read for ACK.

Function
REQ-016 A request SHALL be accepted on a clk edge where in_valid && in_ready; in_rs and in_data SHALL be latched on that edge; ack_err SHALL clear on that edge.
REQ-017 in_ready SHALL be 1 only in IDLE; busy SHALL equal !in_ready.
REQ-018 States SHALL be IDLE, START, BYTE, ACK, STOP, HOLD; a quarter-tick SHALL pulse every DIV clk cycles while not IDLE, and the divider SHALL restart on acceptance.
REQ-019 Each state slot SHALL last 4 quarters (Q0-Q3). START: SDA=1/SCL=1, SDA=1/SCL=1, SDA=0/SCL=1, SDA=0/SCL=0.
REQ-020 Data bit slot: SDA updated at Q0 entry with SCL=0; SCL=1 in Q1 and Q2; SCL=0 in Q3; MSB first.
REQ-021 ACK slot: SDA released; SDA sampled at Q2 entry; 0 = ACK.
REQ-022 STOP: SDA=0/SCL=0, SDA=0/SCL=1, SDA=1/SCL=1, SDA=1/SCL=1.
REQ-023 The transaction SHALL be START, address byte {DEV_ADDR,0}, four payload bytes, STOP.
REQ-024 Payload byte format SHALL be {nibble[3:0], BACKLIGHT, EN, 1'b0, in_rs}.
REQ-025 Payload order SHALL be: high nibble with EN=1, high nibble with EN=0, low nibble with EN=1, low nibble with EN=0.
REQ-026 A full transaction SHALL take 47 slots, i.e. 188*DIV clk cycles from acceptance to the end of STOP.
REQ-027 On NACK, the block SHALL set ack_err, skip the remaining bytes, go directly to STOP, then return to IDLE with no HOLD.
REQ-028 If in_rs=0 and in_data is 8'h01, 8'h02 or 8'h03, the block SHALL enter HOLD for LONG_WAIT cycles after STOP; otherwise it SHALL return to IDLE directly after STOP.
REQ-029 in_valid asserted while busy SHALL be ignored; nothing SHALL be queued.
REQ-030 The block SHALL accept back-to-back requests: in_ready SHALL rise one cycle after STOP or HOLD completes.

Reset
REQ-031 While rst is high, the block SHALL be in IDLE with in_ready=1, busy=0, ack_err=0, and scl and sda both Z.
REQ-032 rst asserted mid-transaction SHALL release scl and sda within the same cycle, asynchronously; no STOP is generated and the request is discarded.

Verification
REQ-033 Write data: DIV=4, in_rs=1, in_data=8'h50, slave ACKs all bytes -> bytes observed 0x4E, 0x5D, 0x59, 0x0D, 0x09; in_ready returns 752 cycles after acceptance; ack_err=0.
REQ-034 Clear command: in_rs=0, in_data=8'h01, LONG_WAIT=100 -> payload bytes 0x0C, 0x08, 0x1C, 0x18; busy stays high for a further 100 cycles after STOP.
REQ-035 Address NACK: slave leaves SDA high in the first ACK slot -> STOP immediately follows, ack_err=1, in_ready=1 after 11 slots (44*DIV cycles); the next acceptance clears ack_err.
REQ-036 Mid-stream NACK: slave NACKs the third payload byte -> STOP follows that ACK slot, the fourth payload byte is never driven, ack_err=1.
REQ-037 Reset during a data bit: pulse rst -> scl and sda both Z in the same cycle, in_ready=1 after release, and a new request completes normally.
REQ-038 Busy ignore and back-to-back: hold in_valid high during a transaction, then issue two requests in succession -> only one transaction per acceptance; the second START begins one cycle after in_ready rises.
